matchblock_freeze_ctrl: RTL and testbench

// Freeze-safe isolation shell placed between the pnode stream and one match block (hard or memory) for partial reconfig.

---
 rtl/matchblock_pkg.sv | 40 ++++
 rtl/mb_result_fifo.sv | 87 ++++++++
 rtl/matchblock_freeze_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_matchblock_freeze_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matchblock_pkg.sv
// Shared types and constants for the match-block freeze shell.
// Contents:
//   mb_state_e   - shell state (IDLE, RUN, DRAIN, FROZEN), encoded as reported in STATUS[1:0]
//   CSR_ADDR_*   - Avalon update-slave register addresses
//   STAT_*       - STATUS register bit positions
//   pack_status  - assembles the STATUS read word
package matchblock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      FROZEN = 2'd3
   } mb_state_e;

   localparam logic CSR_ADDR_STATUS  = 1'b0;
   localparam logic CSR_ADDR_DROPCNT = 1'b1;

   localparam int STAT_STATE_LSB = 0;
   localparam int STAT_TMO_BIT   = 2;
   localparam int STAT_FACK_BIT  = 3;
   localparam int STAT_LEVEL_LSB = 8;
   localparam int STAT_INFLT_LSB = 16;

   function automatic logic [31:0] pack_status(input mb_state_e  st,
                                               input logic       tmo_err,
                                               input logic       fack,
                                               input logic [3:0] level,
                                               input logic [7:0] inflt);
      logic [31:0] s;
      s = 32'd0;
      s[STAT_STATE_LSB +: 2] = st;
      s[STAT_TMO_BIT]        = tmo_err;
      s[STAT_FACK_BIT]       = fack;
      s[STAT_LEVEL_LSB +: 4] = level;
      s[STAT_INFLT_LSB +: 8] = inflt;
      return s;
   endfunction

endpackage

// File: rtl/mb_result_fifo.sv
// Small synchronous FIFO holding match-block results until downstream acks them.
// A pushed word is visible at data_o on the cycle after the push. Push while
// full is accepted only together with a pop. flush_i empties the FIFO.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             discard all entries
//   push_i / data_i     write request and data
//   pop_i               remove head entry
//   data_o              head entry
//   full_o / empty_o    occupancy flags
//   level_o             number of stored entries
module mb_result_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == (AW+1)'(DEPTH));
   assign level_o   = cnt_q;
   assign data_o    = mem_q[rd_ptr_q];
   assign pop_ok_s  = pop_i & ~empty_o;
   assign push_ok_s = push_i & (~full_o | pop_i);

   // Pointer and count next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage; cleared on reset so the head reads zero when empty after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok_s && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/matchblock_freeze_ctrl.sv
// Freeze-safe isolation shell between the pnode stream and one match block.
// Flits pass to the block only in RUN; results are buffered in a small FIFO.
// A freeze request (local AND global) drains outstanding work, then isolates
// the block and raises freeze_ack. Flits offered while IDLE or FROZEN are
// accepted and counted in DROPCNT.
// Ports:
//   clock, reset                          clock, asynchronous active-low reset
//   avs_update_*                          CSR slave: 0=STATUS, 1=DROPCNT; readdata 1 cycle after read
//   coe_localfreeze/globalfreeze/enable   control inputs
//   mask_pnode_*                          upstream flit stream
//   mask_data_*                           downstream result stream (FIFO head)
//   blk_pnode_*                           flits to the block
//   blk_data_*                            results from the block
//   freeze_ack                            high while FROZEN
module matchblock_freeze_ctrl
   import matchblock_pkg::*;
#(
   parameter int PNODE_W    = 138,
   parameter int RES_W      = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_INFLT  = 15,
   parameter int DRAIN_TMO  = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               avs_update_write,
   input  logic               avs_update_read,
   input  logic [31:0]        avs_update_writedata,
   input  logic               avs_update_address,
   output logic [31:0]        avs_update_readdata,
   input  logic               coe_localfreeze,
   input  logic               coe_globalfreeze,
   input  logic               coe_enable,
   input  logic [PNODE_W-1:0] mask_pnode_data,
   input  logic               mask_pnode_valid,
   output logic               mask_pnode_ready,
   output logic [RES_W-1:0]   mask_data_out,
   output logic               mask_data_valid,
   input  logic               mask_data_ack,
   output logic [PNODE_W-1:0] blk_pnode_data,
   output logic               blk_pnode_valid,
   input  logic               blk_pnode_ready,
   input  logic [RES_W-1:0]   blk_data_out,
   input  logic               blk_data_valid,
   output logic               blk_data_ack,
   output logic               freeze_ack
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W = $clog2(DRAIN_TMO + 1);

   mb_state_e         state_q, state_d;
   logic [7:0]        inflt_q, inflt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              tmo_err_q, tmo_err_d;
   logic [31:0]       dropcnt_q, dropcnt_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              frz_s, room_s, active_s;
   logic              blk_xfer_s, res_xfer_s, out_xfer_s, drop_s;
   logic              stat_clr_s, drop_clr_s;
   logic              fifo_full_s, fifo_empty_s;
   logic [LVL_W-1:0]  fifo_level_s;
   logic              unused_wdata_s;

   assign frz_s      = coe_globalfreeze & coe_localfreeze;
   assign room_s     = (inflt_q < 8'(MAX_INFLT));
   assign active_s   = (state_q == RUN) | (state_q == DRAIN);
   assign blk_xfer_s = blk_pnode_valid & blk_pnode_ready;
   assign out_xfer_s = mask_data_valid & mask_data_ack;
   // Ack a result when it fits now, including when a downstream pop frees a slot this cycle.
   assign blk_data_ack = blk_data_valid & (~fifo_full_s | out_xfer_s) & active_s;
   assign res_xfer_s   = blk_data_valid & blk_data_ack;
   assign mask_data_valid = ~fifo_empty_s & (state_q != FROZEN);
   assign drop_s     = mask_pnode_valid & mask_pnode_ready & ((state_q == IDLE) | (state_q == FROZEN));
   assign stat_clr_s = avs_update_write & (avs_update_address == CSR_ADDR_STATUS) & avs_update_writedata[STAT_TMO_BIT];
   assign drop_clr_s = avs_update_write & (avs_update_address == CSR_ADDR_DROPCNT);
   assign unused_wdata_s = ^{avs_update_writedata[31:3], avs_update_writedata[1:0]};
   assign avs_update_readdata = rdata_q;

   mb_result_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .flush_i (state_q == FROZEN),
      .push_i  (res_xfer_s),
      .pop_i   (out_xfer_s),
      .data_i  (blk_data_out),
      .data_o  (mask_data_out),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .level_o (fifo_level_s)
   );

   // Per-state stream gating and freeze acknowledge.
   always_comb begin
      mask_pnode_ready = 1'b0;
      blk_pnode_data   = '0;
      blk_pnode_valid  = 1'b0;
      freeze_ack       = 1'b0;
      case (state_q)
         IDLE: begin
            mask_pnode_ready = 1'b1;
         end
         RUN: begin
            // Valid is also gated by the in-flight limit so the block never
            // takes a flit that upstream did not hand over.
            mask_pnode_ready = blk_pnode_ready & room_s;
            blk_pnode_data   = mask_pnode_data;
            blk_pnode_valid  = mask_pnode_valid & room_s;
         end
         FROZEN: begin
            mask_pnode_ready = 1'b1;
            freeze_ack       = 1'b1;
         end
         default: begin
            mask_pnode_ready = 1'b0;
         end
      endcase
   end

   // State, drain timer and timeout flag next-state.
   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      tmo_err_d = tmo_err_q;
      case (state_q)
         IDLE: begin
            if (frz_s) state_d = FROZEN;
            else if (coe_enable) state_d = RUN;
            else state_d = IDLE;
         end
         RUN: begin
            if (frz_s) begin
               state_d = DRAIN;
               tmo_d   = '0;
            end else if (!coe_enable) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            tmo_d = tmo_q + TMO_W'(1);
            if ((inflt_q == 8'd0) && fifo_empty_s) begin
               state_d = FROZEN;
            end else if (tmo_q == TMO_W'(DRAIN_TMO - 1)) begin
               // FROZEN lands exactly DRAIN_TMO cycles after DRAIN entry.
               state_d   = FROZEN;
               tmo_err_d = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         FROZEN: begin
            if (!frz_s) state_d = IDLE;
            else state_d = FROZEN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (stat_clr_s) tmo_err_d = 1'b0;
      else tmo_err_d = tmo_err_d;
   end

   // In-flight count, drop counter and CSR read data next-state.
   always_comb begin
      inflt_d   = inflt_q;
      dropcnt_d = dropcnt_q;
      rdata_d   = 32'd0;
      // Work outstanding at freeze is lost with the reconfigured block.
      if (state_q == FROZEN) inflt_d = 8'd0;
      else if (blk_xfer_s && !res_xfer_s) inflt_d = inflt_q + 8'd1;
      else if (!blk_xfer_s && res_xfer_s && (inflt_q != 8'd0)) inflt_d = inflt_q - 8'd1;
      else inflt_d = inflt_q;

      if (drop_clr_s) dropcnt_d = 32'd0;
      else if (drop_s && (dropcnt_q != 32'hFFFF_FFFF)) dropcnt_d = dropcnt_q + 32'd1;
      else dropcnt_d = dropcnt_q;

      if (avs_update_read) begin
         rdata_d = (avs_update_address == CSR_ADDR_DROPCNT) ? dropcnt_q
                 : pack_status(state_q, tmo_err_q, (state_q == FROZEN), 4'(fifo_level_s), inflt_q);
      end else begin
         rdata_d = 32'd0;
      end
   end

   // Control registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         inflt_q   <= 8'd0;
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
         dropcnt_q <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         inflt_q   <= inflt_d;
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
         dropcnt_q <= dropcnt_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule

// File: tb/tb_matchblock_freeze_ctrl.sv
module tb_matchblock_freeze_ctrl;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          avs_update_write, avs_update_read, avs_update_address;
   logic [31:0]   avs_update_writedata;
   wire  [31:0]   avs_update_readdata;
   logic          coe_localfreeze, coe_globalfreeze, coe_enable;
   logic [137:0]  mask_pnode_data;
   logic          mask_pnode_valid;
   wire           mask_pnode_ready;
   wire  [9:0]    mask_data_out;
   wire           mask_data_valid;
   logic          mask_data_ack;
   wire  [137:0]  blk_pnode_data;
   wire           blk_pnode_valid;
   logic          blk_pnode_ready;
   logic [9:0]    blk_data_out;
   logic          blk_data_valid;
   wire           blk_data_ack;
   wire           freeze_ack;

   always #5 clock = ~clock;

   matchblock_freeze_ctrl dut (
      .clock                (clock),
      .reset                (rst_n),
      .avs_update_write     (avs_update_write),
      .avs_update_read      (avs_update_read),
      .avs_update_writedata (avs_update_writedata),
      .avs_update_address   (avs_update_address),
      .avs_update_readdata  (avs_update_readdata),
      .coe_localfreeze      (coe_localfreeze),
      .coe_globalfreeze     (coe_globalfreeze),
      .coe_enable           (coe_enable),
      .mask_pnode_data      (mask_pnode_data),
      .mask_pnode_valid     (mask_pnode_valid),
      .mask_pnode_ready     (mask_pnode_ready),
      .mask_data_out        (mask_data_out),
      .mask_data_valid      (mask_data_valid),
      .mask_data_ack        (mask_data_ack),
      .blk_pnode_data       (blk_pnode_data),
      .blk_pnode_valid      (blk_pnode_valid),
      .blk_pnode_ready      (blk_pnode_ready),
      .blk_data_out         (blk_data_out),
      .blk_data_valid       (blk_data_valid),
      .blk_data_ack         (blk_data_ack),
      .freeze_ack           (freeze_ack)
   );

   typedef struct {
      logic       en, lf, gf, brdy;
      logic [1:0] st;
      logic       rdy, fack;
   } vec_t;

   typedef struct {
      logic [9:0] d;
      int         due;
   } pend_t;

   vec_t        vecs[11];
   pend_t       blk_q[$];
   logic [9:0]  exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          exp_drop = 0;
   int          peak = 0;
   bit          exp_run = 1'b0;
   bit          answer_en = 1'b1;
   bit          track_peak = 1'b0;
   bit          up_acc = 1'b0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: observe transfers before the edge, then update the block model after it.
   task automatic cycle();
      @(negedge clock);
      up_acc = mask_pnode_valid && mask_pnode_ready;
      if (up_acc) begin
         if (exp_run) begin
            chk("blk_take", {blk_pnode_valid, blk_pnode_ready}, 2'b11);
            chk("blk_data", blk_pnode_data, mask_pnode_data);
            exp_q.push_back(mask_pnode_data[9:0]);
         end else begin
            chk("drop_isolated", blk_pnode_valid, 1'b0);
            exp_drop++;
         end
      end
      if (blk_pnode_valid && blk_pnode_ready) blk_q.push_back(pend_t'{d: blk_pnode_data[9:0], due: cyc + 3});
      if (blk_data_valid && blk_data_ack && blk_q.size() > 0) void'(blk_q.pop_front());
      if (mask_data_valid && mask_data_ack) begin
         if (exp_q.size() == 0) chk("spurious_result", mask_data_out, 10'h3ff ^ mask_data_out);
         else chk("result", mask_data_out, exp_q.pop_front());
      end
      if (track_peak && int'(avs_update_readdata[23:16]) > peak) peak = int'(avs_update_readdata[23:16]);
      @(posedge clock);
      #1;
      cyc++;
      if (answer_en && blk_q.size() > 0 && blk_q[0].due <= cyc) begin
         blk_data_valid = 1'b1;
         blk_data_out   = blk_q[0].d;
      end else begin
         blk_data_valid = 1'b0;
         blk_data_out   = 10'd0;
      end
   endtask

   task automatic send_flit();
      logic [159:0] r;
      bit got;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      mask_pnode_data  = r[137:0];
      mask_pnode_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         got = up_acc;
      end
      chk("send_timeout", got, 1'b1);
      mask_pnode_valid = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) cycle();
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic csr_read(input logic addr, output logic [31:0] d);
      avs_update_read    = 1'b1;
      avs_update_address = addr;
      cycle();
      d = avs_update_readdata;
      avs_update_read = 1'b0;
   endtask

   task automatic csr_write(input logic addr, input logic [31:0] d);
      avs_update_write     = 1'b1;
      avs_update_address   = addr;
      avs_update_writedata = d;
      cycle();
      avs_update_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [1:0]  prev_st;
      logic        prev_fack;
      int          n;

      //           en    lf    gf    brdy  st     rdy   fack
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};

      rst_n = 1'b0;
      avs_update_write = 1'b0; avs_update_read = 1'b0; avs_update_address = 1'b0;
      avs_update_writedata = 32'd0;
      coe_localfreeze = 1'b0; coe_globalfreeze = 1'b0; coe_enable = 1'b0;
      mask_pnode_data = '0; mask_pnode_valid = 1'b0; mask_data_ack = 1'b1;
      blk_pnode_ready = 1'b1; blk_data_out = 10'd0; blk_data_valid = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", mask_pnode_ready, 1'b1);
      chk("rst_outs", {freeze_ack, blk_pnode_valid, blk_data_ack, mask_data_valid}, 4'b0000);
      chk("rst_rdata", avs_update_readdata, 32'd0);
      @(negedge clock);
      rst_n = 1'b1;

      // State transition table; readdata registers the status seen before each edge.
      prev_st = 2'd0;
      prev_fack = 1'b0;
      avs_update_read = 1'b1;
      avs_update_address = 1'b0;
      for (int i = 0; i < 11; i++) begin
         coe_enable = vecs[i].en; coe_localfreeze = vecs[i].lf;
         coe_globalfreeze = vecs[i].gf; blk_pnode_ready = vecs[i].brdy;
         cycle();
         chk("vec_ready", mask_pnode_ready, vecs[i].rdy);
         chk("vec_fack", freeze_ack, vecs[i].fack);
         chk("vec_status", avs_update_readdata[3:0], {prev_fack, 1'b0, prev_st});
         prev_st = vecs[i].st;
         prev_fack = vecs[i].fack;
      end
      avs_update_read = 1'b0;

      // 8 flits, 3-cycle block latency.
      coe_enable = 1'b1;
      cycle();
      exp_run = 1'b1;
      avs_update_read = 1'b1; avs_update_address = 1'b0;
      track_peak = 1'b1; peak = 0;
      for (int i = 0; i < 8; i++) send_flit();
      wait_empty(60);
      track_peak = 1'b0;
      avs_update_read = 1'b0;
      chk("inflt_peak", peak, 3);
      csr_read(1'b1, rd);
      chk("dropcnt_run", rd, 32'd0);

      // Downstream stalled: FIFO fills, block held off, nothing lost.
      mask_data_ack = 1'b0;
      for (int i = 0; i < 6; i++) send_flit();
      repeat (10) cycle();
      chk("stall_blk_ack", {blk_data_valid, blk_data_ack, mask_data_valid}, 3'b101);
      csr_read(1'b0, rd);
      chk("stall_level", rd[11:8], 4'd4);
      chk("stall_inflt", rd[23:16], 8'd2);
      mask_data_ack = 1'b1;
      wait_empty(40);

      // Freeze with two flits outstanding.
      send_flit();
      send_flit();
      exp_run = 1'b0;
      coe_localfreeze = 1'b1; coe_globalfreeze = 1'b1;
      cycle();
      chk("drain_ready", mask_pnode_ready, 1'b0);
      n = 0;
      while (!freeze_ack && n < 40) begin cycle(); n++; end
      chk("drain_frozen", freeze_ack, 1'b1);
      chk("drain_results_out", exp_q.size(), 0);
      csr_read(1'b0, rd);
      chk("drain_status", rd[11:0], 12'h00b);
      coe_localfreeze = 1'b0; coe_globalfreeze = 1'b0;
      cycle();
      chk("unfreeze_idle", freeze_ack, 1'b0);

      // Block never answers: drain timeout.
      cycle();
      exp_run = 1'b1;
      answer_en = 1'b0;
      send_flit();
      exp_run = 1'b0;
      coe_localfreeze = 1'b1; coe_globalfreeze = 1'b1;
      cycle();
      n = 0;
      while (!freeze_ack && n < 400) begin cycle(); n++; end
      chk("tmo_cycles", n, 255);
      blk_q.delete();
      exp_q.delete();
      csr_read(1'b0, rd);
      chk("tmo_status", rd[3:0], 4'hf);
      csr_write(1'b0, 32'h0000_0000);
      csr_read(1'b0, rd);
      chk("tmo_keep", rd[2], 1'b1);
      csr_write(1'b0, 32'h0000_0004);
      csr_read(1'b0, rd);
      chk("tmo_clear", rd[2], 1'b0);

      // FROZEN drops flits.
      exp_drop = 0;
      for (int i = 0; i < 5; i++) send_flit();
      chk("drop_seen", exp_drop, 5);
      csr_read(1'b1, rd);
      chk("dropcnt5", rd, 32'd5);
      csr_write(1'b1, 32'h0000_dead);
      csr_read(1'b1, rd);
      chk("dropcnt_clr", rd, 32'd0);
      mask_pnode_valid = 1'b1;
      avs_update_write = 1'b1; avs_update_address = 1'b1;
      cycle();
      avs_update_write = 1'b0; mask_pnode_valid = 1'b0;
      csr_read(1'b1, rd);
      chk("clear_wins", rd, 32'd0);

      // Reset in the middle of DRAIN.
      coe_localfreeze = 1'b0; coe_globalfreeze = 1'b0;
      cycle();
      cycle();
      exp_run = 1'b1;
      send_flit();
      exp_run = 1'b0;
      coe_localfreeze = 1'b1; coe_globalfreeze = 1'b1;
      cycle();
      chk("pre_rst_drain", mask_pnode_ready, 1'b0);
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", mask_pnode_ready, 1'b1);
      chk("arst_outs", {freeze_ack, blk_pnode_valid, blk_data_ack, mask_data_valid}, 4'b0000);
      chk("arst_data", {blk_pnode_data, mask_data_out}, 148'd0);
      coe_localfreeze = 1'b0; coe_globalfreeze = 1'b0; coe_enable = 1'b0;
      blk_q.delete();
      exp_q.delete();
      blk_data_valid = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      csr_read(1'b0, rd);
      chk("post_rst_status", rd, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
